// File: rtl/lfsr_pkg.sv
// Shared constants and next-state function for the 5-bit Fibonacci LFSR.
// Used by both the RTL and the reference model in the bench.
package lfsr_pkg;

  localparam int LFSR_W = 5;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 5'b10100;
  localparam logic [LFSR_W-1:0] LFSR_DEFAULT_SEED = 5'h01;

  // x^5 + x^3 + 1, shift left with feedback into bit 0; all-zero lock-up reloads seed
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q,
                                                  input logic [LFSR_W-1:0] seed);
    logic fb;
    if (q == '0) begin
      return seed;
    end
    fb = ^(q & LFSR_TAPS);
    return {q[LFSR_W-2:0], fb};
  endfunction

endpackage

// File: rtl/lfsr_5bit_rng_if.sv
// Output bus of the LFSR random source; the generator drives, drivers consume.
interface lfsr_5bit_rng_if;

  logic [lfsr_pkg::LFSR_W-1:0] data;

  modport master (output data);
  modport slave  (input  data);

endinterface

// File: rtl/lfsr_5bit_rng.sv
// Free-running 5-bit maximal-length LFSR; a new pseudo-random word every clock.
// The output comes straight from the state register, so no input reaches it combinationally.
module lfsr_5bit_rng
  import lfsr_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = LFSR_DEFAULT_SEED
) (
  input  logic                   clk,
  input  logic                   nreset,
  lfsr_5bit_rng_if.master        bus
);

  if (SEED == '0) begin : g_bad_seed
    $error("lfsr_5bit_rng: SEED must be non-zero");
  end

  logic [LFSR_W-1:0] q;

  // nreset is active-high despite its name, matching the rest of the codebase
  always_ff @(posedge clk or posedge nreset) begin
    if (nreset) begin
      q <= SEED;
    end else begin
      q <= lfsr_next(q, SEED);
    end
  end

  assign bus.data = q;

  // A zero state only arises from corruption; flag it while recovery reloads SEED
  a_never_zero : assert property (@(posedge clk) disable iff (nreset) q != '0)
    else $warning("lfsr_5bit_rng: state is zero, reloading SEED");

  a_step : assert property (@(posedge clk) disable iff (nreset)
      (!$past(nreset) && $past(q) != '0 && q != '0) |-> q == lfsr_next($past(q), SEED));

endmodule

// File: tb/tb_lfsr_5bit_rng.sv
// Directed bench for lfsr_5bit_rng: two default-seed instances and one SEED=1F instance,
// checked through a per-edge expectation queue plus directed constant checks.
module tb_lfsr_5bit_rng;
  import lfsr_pkg::*;

  typedef struct {
    logic [4:0] exp_a;
    logic [4:0] exp_b;
    logic [4:0] exp_s;
  } exp_t;

  logic clk = 1'b0;
  logic nreset;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];
  logic [4:0] model_a, model_b, model_s;
  logic [4:0] seq_tab [9];
  int   seen [32];
  int   distinct;
  bit   found;

  lfsr_5bit_rng_if bus_a ();
  lfsr_5bit_rng_if bus_b ();
  lfsr_5bit_rng_if bus_s ();

  lfsr_5bit_rng dut_a (.clk(clk), .nreset(nreset), .bus(bus_a));
  lfsr_5bit_rng dut_b (.clk(clk), .nreset(nreset), .bus(bus_b));
  lfsr_5bit_rng #(.SEED(5'h1F)) dut_s (.clk(clk), .nreset(nreset), .bus(bus_s));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Push the expectation for the coming edge, advance one clock, pop and compare.
  task automatic step(input string tag);
    exp_t e;
    exp_t got;
    e.exp_a = lfsr_next(model_a, 5'h01);
    e.exp_b = lfsr_next(model_b, 5'h01);
    e.exp_s = lfsr_next(model_s, 5'h1F);
    sb.push_back(e);
    model_a = e.exp_a;
    model_b = e.exp_b;
    model_s = e.exp_s;
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check({tag, "_a"}, bus_a.data, got.exp_a);
    check({tag, "_b"}, bus_b.data, got.exp_b);
    check({tag, "_s"}, bus_s.data, got.exp_s);
  endtask

  task automatic reset_models();
    model_a = 5'h01;
    model_b = 5'h01;
    model_s = 5'h1F;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    seq_tab = '{5'h02, 5'h04, 5'h09, 5'h12, 5'h05, 5'h0B, 5'h16, 5'h0C, 5'h19};
    nreset = 1'b1;
    reset_models();

    // Reset held across several clock edges
    repeat (3) @(posedge clk);
    #1;
    check("reset_a", bus_a.data, 5'h01);
    check("reset_b", bus_b.data, 5'h01);
    check("reset_s", bus_s.data, 5'h1F);

    // Known sequence after release; SEED=1F instance gives 1E, 1C first
    @(negedge clk);
    nreset = 1'b0;
    for (int i = 0; i < 9; i++) begin
      step("seq");
      check($sformatf("seq_tab%0d", i), bus_a.data, seq_tab[i]);
      if (i == 0) check("seed1f_e1", bus_s.data, 5'h1E);
      if (i == 1) check("seed1f_e2", bus_s.data, 5'h1C);
    end

    // Full period from a fresh reset
    @(negedge clk);
    nreset = 1'b1;
    reset_models();
    #1;
    check("rst2_a", bus_a.data, 5'h01);
    @(negedge clk);
    nreset = 1'b0;
    for (int v = 0; v < 32; v++) seen[v] = 0;
    for (int i = 0; i < 31; i++) begin
      step("period");
      seen[bus_a.data]++;
    end
    distinct = 0;
    for (int v = 1; v < 32; v++) if (seen[v] == 1) distinct++;
    check("period_distinct", distinct, 31);
    check("period_zero", seen[0], 0);
    check("period_wrap", bus_a.data, 5'h01);

    // Run to state 16, then assert reset between edges
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step("to16");
      if (bus_a.data == 5'h16) found = 1'b1;
    end
    check("reach16", found, 1'b1);
    @(negedge clk);
    nreset = 1'b1;
    reset_models();
    #1;
    check("async_rst_a", bus_a.data, 5'h01);
    check("async_rst_s", bus_s.data, 5'h1F);
    @(posedge clk);
    #1;
    check("rst_hold_a", bus_a.data, 5'h01);
    @(negedge clk);
    nreset = 1'b0;
    step("after_rst");
    check("after_rst_02", bus_a.data, 5'h02);
    repeat (4) step("run");

    // Lock-up recovery: zero the state of one instance for a cycle
    @(negedge clk);
    force dut_a.q = 5'h00;
    #1;
    check("forced_zero", bus_a.data, 5'h00);
    release dut_a.q;
    model_a = 5'h00;
    step("lockup");
    check("lockup_seed", bus_a.data, 5'h01);
    repeat (3) step("post_lockup");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
